param_stack_unit: RTL
=====================

// Module: param_stack_unit
// PURPOSE
//   Parametrised LIFO stack serving the control unit's push/pop signals (call/return and
//   operand save/restore). Next generation of the fixed stack: configurable width and depth,
//   registered top-of-stack output, single-cycle replace-top, halt freeze, sticky
//   overflow/underflow flags. Sits beside the register file; driven by controlunit.
// PARAMETERS
//   WIDTH   32  data word width in bits
//   DEPTH   16  number of stack entries (>=2)
//   PTR_W    5  width of count; must satisfy 2**PTR_W > DEPTH
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   halt       in   1      1 = freeze: push/pop ignored, all state held
//   push       in   1      push din (one word per cycle)
//   pop        in   1      pop top entry
//   din        in   WIDTH  data to push / replace
//   clr_err    in   1      clear sticky error flags
//   top        out  WIDTH  registered top-of-stack value; 0 when empty
//   count      out  PTR_W  entries held, 0..DEPTH
//   empty      out  1      count==0
//   full       out  1      count==DEPTH
//   overflow   out  1      sticky: push (without pop) attempted while full
//   underflow  out  1      sticky: pop (without push) attempted while empty
// BEHAVIOUR
//   - Reset (sync, reset=1 at clk edge): count=0, top=0, overflow=0, underflow=0; empty=1,
//     full=0. Memory array not cleared. reset overrides halt and all ops the same edge.
//   - All updates on rising clk; outputs reflect an operation the cycle after its edge
//     (latency 1). empty/full are decoded from registered count (no combinational path from
//     push/pop).
//   - halt=1: push/pop/din ignored, no flag set; clr_err still honoured.
//   - push=1,pop=0: if !full: mem[count]<=din, count+1, top<=din. If full: no state change,
//     overflow<=1.
//   - push=0,pop=1: if !empty: count-1, top<=mem[count-2] when count>=2, else top<=0.
//     If empty: no state change, underflow<=1.
//   - push=1,pop=1 (replace-top): if !empty: mem[count-1]<=din, top<=din, count unchanged
//     (legal when full, no overflow). If empty: behaves as push-only, no underflow.
//   - Neither asserted: hold.
//   - clr_err=1 clears overflow/underflow; a new error event on the same edge wins (flag=1).
//   - Errored operations never corrupt memory, count or top.
//   - Index arithmetic in PTR_W bits; no wrap: count saturates at 0 and DEPTH via the above
//     guards.
//   - Reset mid-operation (e.g. during burst push): discards contents logically; next push
//     writes mem[0].
// TESTING
//   1. reset, push 0xA,0xB,0xC -> count=3, top=0xC; pop x3 -> top 0xB,0xA,0, empty=1.
//   2. DEPTH=16: push 16 words (1..16) -> full=1, top=16; 17th push -> overflow=1,
//      count=16, top=16; pop -> top=15.
//   3. empty: pop -> underflow=1, count=0, top=0; clr_err -> flags 0; clr_err with pop on
//      empty same cycle -> underflow=1.
//   4. count=2, top=0x5; push+pop din=0x9 -> count=2, top=0x9; pop -> prior entry;
//      full+push+pop -> no overflow.
//   5. count=3; halt=1 with push/pop pulses for 4 cycles -> count, top, flags unchanged;
//      release halt, push -> resumes.
//   6. push 5 words, assert reset on 3rd push -> next cycle count=0, top=0; push 0x7 ->
//      count=1, top=0x7.

Source files
------------

// File: rtl/param_stack_unit.sv
// Parametrised LIFO stack with a registered top-of-stack, single-cycle replace-top,
// halt freeze and sticky overflow/underflow flags.
module param_stack_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);
  localparam logic [PTR_W-1:0] TWO     = PTR_W'(2);

  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE} op_e;

  logic [WIDTH-1:0] mem [DEPTH];

  op_e              op;
  logic [PTR_W-1:0] count_d;
  logic [WIDTH-1:0] top_d;
  logic             overflow_d;
  logic             underflow_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_P);

  // Replace-top on an empty stack degrades to a plain push; halt masks every operation.
  always_comb begin
    op = OP_NONE;
    if (!halt) begin
      unique case ({push, pop})
        2'b10:   op = OP_PUSH;
        2'b01:   op = OP_POP;
        2'b11:   op = empty ? OP_PUSH : OP_REPLACE;
        default: op = OP_NONE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    count_d     = count;
    top_d       = top;
    overflow_d  = overflow  & ~clr_err;
    underflow_d = underflow & ~clr_err;
    we          = 1'b0;
    waddr       = AW'(count);
    raddr       = AW'(count - TWO);
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count + ONE;
          top_d   = din;
        end
      end
      OP_POP: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          count_d = count - ONE;
          top_d   = (count >= TWO) ? mem[raddr] : '0;
        end
      end
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = AW'(count - ONE);
        top_d = din;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      top       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_d;
      top       <= top_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= din;
  end

endmodule
